// File: rtl/signed_sub_with_saturation_pipelined.sv
// signed_sub_with_saturation_pipelined
// Two-stage valid/ready pipeline computing a saturated signed a - b.
// S1 captures the operand pair; S2 forms the W+1-bit difference, clamps it
// to the W-bit signed range and flags which way it clamped.
// Optional feature macro: SIGNED_SUB_SAT_COUNT_EN compiles in the sticky
// saturation event counter; without it sat_count is tied to zero.
module signed_sub_with_saturation_pipelined #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [W-1:0]     diff,
  output logic             sat_pos,
  output logic             sat_neg,
  output logic [CNT_W-1:0] sat_count
);

  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] a_q, b_q;
  logic         s1_valid_q;
  logic [W-1:0] diff_q, diff_d;
  logic         sat_pos_q, sat_pos_d;
  logic         sat_neg_q, sat_neg_d;
  logic         s2_valid_q;
  logic         s1_load, s2_load;
  logic [W:0]   full_d;

  // S2 frees up when empty or when the consumer takes its result; S1 can
  // only move forward if S2 does, so up_ready is combinational from down_ready.
  assign s2_load  = !s2_valid_q || down_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign up_ready = s1_load;

  // Full-precision difference and clamp: the top two bits of the W+1-bit
  // result disagree exactly when the W-bit result would have overflowed.
  always_comb begin
    full_d    = {a_q[W-1], a_q} - {b_q[W-1], b_q};
    diff_d    = full_d[W-1:0];
    sat_pos_d = 1'b0;
    sat_neg_d = 1'b0;
    if (!full_d[W] && full_d[W-1]) begin
      diff_d    = MAX_POS;
      sat_pos_d = 1'b1;
    end else if (full_d[W] && !full_d[W-1]) begin
      diff_d    = MIN_NEG;
      sat_neg_d = 1'b1;
    end
  end

  // Stage 1: operand capture; data only moves on an actual input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      s1_valid_q <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= up_valid;
      if (up_valid) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

  // Stage 2: registered clamped result, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q     <= '0;
      sat_pos_q  <= 1'b0;
      sat_neg_q  <= 1'b0;
      s2_valid_q <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        diff_q    <= diff_d;
        sat_pos_q <= sat_pos_d;
        sat_neg_q <= sat_neg_d;
      end
    end
  end

  assign down_valid = s2_valid_q;
  assign diff       = diff_q;
  assign sat_pos    = sat_pos_q;
  assign sat_neg    = sat_neg_q;

`ifdef SIGNED_SUB_SAT_COUNT_EN
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
  logic             sat_xfer;

  // Count only saturated results actually taken downstream; stick at all-ones.
  assign sat_xfer = s2_valid_q && down_ready && (sat_pos_q || sat_neg_q);

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_xfer && !(&sat_cnt_q)) sat_cnt_d = sat_cnt_q + 1'b1;
  end

  // Saturation event counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_signed_sub_with_saturation_pipelined.sv
// Scoreboard bench for signed_sub_with_saturation_pipelined (W=4, CNT_W=8).
module tb_signed_sub_with_saturation_pipelined;
  localparam int W     = 4;
  localparam int CNT_W = 8;
  localparam int MAXV  = (1 << (W-1)) - 1;
  localparam int MINV  = -(1 << (W-1));

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             up_valid = 1'b0;
  logic             up_ready;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             down_valid;
  logic             down_ready = 1'b1;
  logic [W-1:0]     diff;
  logic             sat_pos;
  logic             sat_neg;
  logic [CNT_W-1:0] sat_count;

  signed_sub_with_saturation_pipelined #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready), .a(a), .b(b),
    .down_valid(down_valid), .down_ready(down_ready),
    .diff(diff), .sat_pos(sat_pos), .sat_neg(sat_neg), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         p;
    logic         n;
    bit           lat;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   model_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    total_cnt++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
  endtask

  function automatic exp_t model(input int av, input int bv, input bit lat);
    exp_t e;
    int   dv;
    dv = av - bv;
    e.p = 1'b0;
    e.n = 1'b0;
    if (dv > MAXV) begin
      dv = MAXV;
      e.p = 1'b1;
    end else if (dv < MINV) begin
      dv = MINV;
      e.n = 1'b1;
    end
    e.d   = dv[W-1:0];
    e.lat = lat;
    e.cyc = 0;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int av, input int bv, input bit lat);
    exp_t e;
    bit   done;
    e = model(av, bv, lat);
    a = av[W-1:0];
    b = bv[W-1:0];
    up_valid = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (up_ready) begin
        e.cyc = cyc;
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    up_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops and compares on every output transfer, checks hold under stall.
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_diff;
  logic         prev_pos, prev_neg;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", int'(down_valid), 1);
          chk("hold_diff", int'(diff), int'(prev_diff));
          chk("hold_flags", int'({sat_pos, sat_neg}), int'({prev_pos, prev_neg}));
        end
        if (down_valid && down_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", int'(diff), -1);
          end else begin
            e = exp_q.pop_front();
            chk("diff", int'(diff), int'(e.d));
            chk("sat_pos", int'(sat_pos), int'(e.p));
            chk("sat_neg", int'(sat_neg), int'(e.n));
            if (e.lat) chk("latency", cyc - e.cyc, 2);
          end
          chk("sat_count", int'(sat_count), model_cnt);
`ifdef SIGNED_SUB_SAT_COUNT_EN
          if ((sat_pos || sat_neg) && model_cnt < (1 << CNT_W) - 1) model_cnt++;
`endif
        end
        prev_stall = down_valid && !down_ready;
        prev_diff  = diff;
        prev_pos   = sat_pos;
        prev_neg   = sat_neg;
      end
    end
  end

  initial begin
    #3;
    chk("rst_up_ready", int'(up_ready), 1);
    chk("rst_down_valid", int'(down_valid), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_flags", int'({sat_pos, sat_neg}), 0);
    chk("rst_sat_count", int'(sat_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_up_ready", int'(up_ready), 1);
    @(posedge clk);
    #1;

    // Streaming directed vectors, down_ready high, latency checked.
    down_ready = 1'b1;
    send(3, 5, 1);
    send(-8, -8, 1);
    send(7, -1, 1);
    send(0, -8, 1);
    send(-8, 1, 1);
    send(-5, 7, 1);
    send(2, -3, 1);
    send(-1, -1, 1);
    send(-7, 1, 1);
    send(6, -1, 1);
    drain();

    // Backpressure: down_ready low for 3 cycles while 4 pairs are offered.
    down_ready = 1'b0;
    fork
      begin
        send(1, -2, 0);
        send(-4, 4, 0);
        send(5, 6, 0);
        send(-6, 3, 0);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("bp_up_ready_low", int'(up_ready), 0);
        chk("bp_down_valid", int'(down_valid), 1);
        @(posedge clk);
        #1;
        down_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-stream with both stages full.
    down_ready = 1'b0;
    send(1, 2, 0);
    send(2, 3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_down_valid", int'(down_valid), 0);
    chk("mid_rst_diff", int'(diff), 0);
    chk("mid_rst_up_ready", int'(up_ready), 1);
    chk("mid_rst_sat_count", int'(sat_count), 0);
    exp_q.delete();
    model_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    down_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_up_ready", int'(up_ready), 1);
    @(posedge clk);
    #1;
    send(-3, 2, 1);
    drain();

    // Counter: 300 saturating transfers, then non-saturating ones.
    for (int i = 0; i < 300; i++) begin
      if (i[0]) send(-8, 1, 0);
      else      send(7, -1, 0);
    end
    drain();
`ifdef SIGNED_SUB_SAT_COUNT_EN
    chk("cnt_sticky_max", int'(sat_count), (1 << CNT_W) - 1);
`else
    chk("cnt_disabled_zero", int'(sat_count), 0);
`endif
    for (int i = 0; i < 5; i++) send(i, 1, 0);
    drain();
`ifdef SIGNED_SUB_SAT_COUNT_EN
    chk("cnt_hold", int'(sat_count), (1 << CNT_W) - 1);
`else
    chk("cnt_hold_zero", int'(sat_count), 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
